// File: rtl/touch_pkg.sv
// Shared definitions for the touch frame-lock block:
// FSM state encoding and datapath widths.
package touch_pkg;

  localparam int COORD_W = 9;
  localparam int SUM_W   = 11;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PRESS_DB   = 2'd1;
  localparam logic [1:0] ST_PRESSED    = 2'd2;
  localparam logic [1:0] ST_RELEASE_DB = 2'd3;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [SUM_W-1:0]   sum_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider producing a one-cycle sample tick
// every DIV clocks.
module sample_tick_gen #(
  parameter int DIV = 100000
) (
  input  logic cclk,
  input  logic rstb,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/touch_frame_lock.sv
// Debounces touchpad presses, averages 4 samples and hands
// the result to the TFT side only at frame boundaries.
module touch_frame_lock
  import touch_pkg::*;
#(
  parameter int SAMPLE_DIV = 100000,
  parameter int Z_THRESH   = 40,
  parameter int DEBOUNCE_N = 4
) (
  input  logic               cclk,
  input  logic               rstb,
  input  logic [COORD_W-1:0] touch_x,
  input  logic [COORD_W-1:0] touch_y,
  input  logic [COORD_W-1:0] touch_z,
  input  logic               new_frame,
  output logic [COORD_W-1:0] locked_touch_x,
  output logic [COORD_W-1:0] locked_touch_y,
  output logic               touch_active,
  output logic               locked_valid
);

  localparam int DBW = $clog2(DEBOUNCE_N + 1);
  localparam logic [DBW-1:0] DBN = DBW'(DEBOUNCE_N);
  localparam coord_t Z_MIN = COORD_W'(Z_THRESH);

  logic           tick;
  logic           press;
  logic [1:0]     state, state_d;
  logic [DBW-1:0] db_cnt, db_d, db_inc;
  logic           reach;
  logic           feed, flush;

  logic [1:0] acc_n;
  sum_t       sum_x, sum_y;
  sum_t       sum_x_n, sum_y_n;
  logic       avg_done;
  coord_t     pend_x, pend_y;
  logic       pend_valid;

  sample_tick_gen #(
    .DIV (SAMPLE_DIV)
  ) u_tick (
    .cclk (cclk),
    .rstb (rstb),
    .tick (tick)
  );

  assign press  = (touch_z >= Z_MIN);
  assign db_inc = db_cnt + 1'b1;
  assign reach  = (db_inc >= DBN);

  // db_cnt is held at zero in IDLE and PRESSED so a
  // single increment starts a fresh debounce run.
  always_comb begin
    state_d = state;
    db_d    = db_cnt;
    feed    = 1'b0;
    flush   = 1'b0;
    if (tick) begin
      unique case (state)
        ST_IDLE, ST_PRESS_DB: begin
          if (press) begin
            db_d    = db_inc;
            state_d = ST_PRESS_DB;
            if (reach) begin
              db_d    = '0;
              state_d = ST_PRESSED;
            end
          end else begin
            db_d    = '0;
            state_d = ST_IDLE;
          end
        end
        ST_PRESSED, ST_RELEASE_DB: begin
          if (press) begin
            db_d    = '0;
            state_d = ST_PRESSED;
            feed    = 1'b1;
          end else begin
            db_d    = db_inc;
            state_d = ST_RELEASE_DB;
            if (reach) begin
              db_d    = '0;
              state_d = ST_IDLE;
              flush   = 1'b1;
            end
          end
        end
        default: begin
          db_d    = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state  <= ST_IDLE;
      db_cnt <= '0;
    end else begin
      state  <= state_d;
      db_cnt <= db_d;
    end
  end

  assign sum_x_n  = sum_x + SUM_W'(touch_x);
  assign sum_y_n  = sum_y + SUM_W'(touch_y);
  assign avg_done = feed && (acc_n == 2'd3);

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      acc_n  <= '0;
      sum_x  <= '0;
      sum_y  <= '0;
      pend_x <= '0;
      pend_y <= '0;
    end else if (flush) begin
      acc_n <= '0;
      sum_x <= '0;
      sum_y <= '0;
    end else if (avg_done) begin
      acc_n  <= '0;
      sum_x  <= '0;
      sum_y  <= '0;
      pend_x <= sum_x_n[SUM_W-1:2];
      pend_y <= sum_y_n[SUM_W-1:2];
    end else if (feed) begin
      acc_n <= acc_n + 1'b1;
      sum_x <= sum_x_n;
      sum_y <= sum_y_n;
    end
  end

  // A fresh average wins over the frame's clear, so a
  // coincident write stays pending for the next frame.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      pend_valid     <= 1'b0;
      locked_touch_x <= '0;
      locked_touch_y <= '0;
      locked_valid   <= 1'b0;
      touch_active   <= 1'b0;
    end else begin
      if (avg_done) begin
        pend_valid <= 1'b1;
      end else if (new_frame) begin
        pend_valid <= 1'b0;
      end
      if (new_frame) begin
        touch_active <= (state == ST_PRESSED) ||
                        (state == ST_RELEASE_DB);
        if (pend_valid) begin
          locked_touch_x <= pend_x;
          locked_touch_y <= pend_y;
          locked_valid   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_touch_frame_lock.sv
// Directed bench for touch_frame_lock with a sample-level
// reference model checked every cycle.
module tb_touch_frame_lock;

  localparam int DIV = 4;
  localparam int DBN = 4;
  localparam int ZT  = 40;

  logic       cclk = 1'b0;
  logic       rstb = 1'b0;
  logic [8:0] touch_x = '0;
  logic [8:0] touch_y = '0;
  logic [8:0] touch_z = '0;
  logic       new_frame = 1'b0;
  logic [8:0] locked_touch_x;
  logic [8:0] locked_touch_y;
  logic       touch_active;
  logic       locked_valid;

  int tests = 0;
  int fails = 0;

  always #5 cclk = ~cclk;

  touch_frame_lock #(
    .SAMPLE_DIV (DIV),
    .DEBOUNCE_N (DBN)
  ) dut (
    .cclk           (cclk),
    .rstb           (rstb),
    .touch_x        (touch_x),
    .touch_y        (touch_y),
    .touch_z        (touch_z),
    .new_frame      (new_frame),
    .locked_touch_x (locked_touch_x),
    .locked_touch_y (locked_touch_y),
    .touch_active   (touch_active),
    .locked_valid   (locked_valid)
  );

  task automatic chk(input string n, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", n, got, exp);
    end
  endtask

  // Model: a press/release flag flips after DBN consecutive
  // disagreeing samples; press samples seen while already
  // pressed are queued and averaged in groups of four.
  int  cyc, run, px, py, mlx, mly, sx, sy;
  bit  m_on, pv, mlv, mact, m_press;
  int  qx[$];
  int  qy[$];

  always @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      cyc = 0; run = 0; m_on = 0;
      qx.delete(); qy.delete();
      px = 0; py = 0; pv = 0;
      mlx = 0; mly = 0; mlv = 0; mact = 0;
    end else begin
      if (new_frame) begin
        mact = m_on;
        if (pv) begin
          mlx = px; mly = py; mlv = 1; pv = 0;
        end
      end
      if (cyc % DIV == DIV - 1) begin
        m_press = (int'(touch_z) >= ZT);
        if (m_press && m_on) begin
          qx.push_back(int'(touch_x));
          qy.push_back(int'(touch_y));
        end
        if (m_press == m_on) begin
          run = 0;
        end else begin
          run++;
          if (run == DBN) begin
            m_on = m_press;
            run = 0;
            if (!m_on) begin
              qx.delete(); qy.delete();
            end
          end
        end
        if (qx.size() == 4) begin
          sx = 0; sy = 0;
          foreach (qx[i]) begin
            sx += qx[i]; sy += qy[i];
          end
          px = sx / 4; py = sy / 4; pv = 1;
          qx.delete(); qy.delete();
        end
      end
      cyc++;
    end
  end

  always @(negedge cclk) begin
    chk("cyc_lx", locked_touch_x, mlx);
    chk("cyc_ly", locked_touch_y, mly);
    chk("cyc_act", touch_active, mact);
    chk("cyc_lv", locked_valid, mlv);
  end

  task automatic period(input int x, input int y,
                        input int z, input int nf_at = -1);
    touch_x = 9'(x);
    touch_y = 9'(y);
    touch_z = 9'(z);
    for (int i = 0; i < DIV; i++) begin
      new_frame = (i == nf_at);
      @(negedge cclk);
    end
    new_frame = 1'b0;
  endtask

  task automatic do_reset();
    #1 rstb = 1'b0;
    touch_x = '0; touch_y = '0; touch_z = '0;
    new_frame = 1'b0;
    @(negedge cclk);
    @(negedge cclk);
    rstb = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge cclk);
    chk("rst_lx", locked_touch_x, 0);
    chk("rst_ly", locked_touch_y, 0);
    chk("rst_act", touch_active, 0);
    chk("rst_lv", locked_valid, 0);
    rstb = 1'b1;

    // steady press, lock after 8 ticks
    repeat (8) period(200, 120, 100);
    period(200, 120, 100, 0);
    chk("s1_lx", locked_touch_x, 200);
    chk("s1_ly", locked_touch_y, 120);
    chk("s1_act", touch_active, 1);
    chk("s1_lv", locked_valid, 1);

    // async reset mid-accumulation, off any clock edge
    period(200, 120, 100);
    #2 rstb = 1'b0;
    #1;
    chk("ar_lx", locked_touch_x, 0);
    chk("ar_ly", locked_touch_y, 0);
    chk("ar_act", touch_active, 0);
    chk("ar_lv", locked_valid, 0);
    @(negedge cclk);
    rstb = 1'b1;

    // truncating average of 10,11,12,14
    repeat (4) period(10, 0, 100);
    period(10, 0, 100);
    period(11, 0, 100);
    period(12, 0, 100);
    period(14, 0, 100);
    period(10, 0, 100, 0);
    chk("avg_lx", locked_touch_x, 11);
    chk("avg_ly", locked_touch_y, 0);

    // two-tick glitch never becomes a press
    do_reset();
    repeat (2) period(0, 0, 100);
    period(0, 0, 0, 0);
    repeat (3) period(0, 0, 0, 1);
    chk("gl_act", touch_active, 0);
    chk("gl_lv", locked_valid, 0);

    // threshold boundary 39 / 40
    do_reset();
    repeat (4) period(5, 5, 39, 0);
    chk("z39_act", touch_active, 0);
    repeat (3) period(5, 5, 40);
    period(5, 5, 40, 0);
    chk("z40_pre", touch_active, 0);
    period(5, 5, 40, 0);
    chk("z40_act", touch_active, 1);

    // average write coincides with new_frame
    do_reset();
    repeat (8) period(50, 60, 100);
    repeat (3) period(100, 80, 100);
    period(100, 80, 100, 3);
    chk("co_old_x", locked_touch_x, 50);
    chk("co_old_y", locked_touch_y, 60);
    period(100, 80, 100, 0);
    chk("co_new_x", locked_touch_x, 100);
    chk("co_new_y", locked_touch_y, 80);

    // outputs hold without frames
    repeat (3) period(0, 0, 0);
    chk("hold_x", locked_touch_x, 100);
    chk("hold_act", touch_active, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
